// File: rtl/piano_pkg.sv
// Note codes shared by the key encoder, FND tone/flat decoders and tone generator.
// The priority helper turns a pressed-key vector into a note code; the lowest key wins.
package piano_pkg;

    localparam int SEL_W    = 4;
    localparam int MAX_KEYS = 15;

    localparam logic [SEL_W-1:0] SEL_NONE = 4'd0;
    localparam logic [SEL_W-1:0] SEL_DO   = 4'd1;
    localparam logic [SEL_W-1:0] SEL_RE   = 4'd2;
    localparam logic [SEL_W-1:0] SEL_MI   = 4'd3;
    localparam logic [SEL_W-1:0] SEL_FA   = 4'd4;
    localparam logic [SEL_W-1:0] SEL_SOL  = 4'd5;
    localparam logic [SEL_W-1:0] SEL_LA   = 4'd6;
    localparam logic [SEL_W-1:0] SEL_SI   = 4'd7;
    localparam logic [SEL_W-1:0] SEL_DO_H = 4'd8;

    // Scan from the top down so that the lowest pressed key overwrites the result last.
    function automatic logic [SEL_W-1:0] prio_encode(input logic [MAX_KEYS-1:0] keys);
        logic [SEL_W-1:0] code;
        code = SEL_NONE;
        for (int k = MAX_KEYS - 1; k >= 0; k--) begin
            if (keys[k]) begin
                code = SEL_W'(k + 1);
            end else begin
                code = code;
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button: two-flop synchroniser, hold-time debounce counter, accepted level
// and a one-cycle rising-edge pulse that is asserted in the same cycle the level rises.
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable,
    output logic rise
);

    localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             stable_d;
    logic             rise_q;
    logic             rise_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Accept a new level only after it has disagreed with the stable level long enough.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        rise_d   = 1'b0;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d = sync2_q;
            rise_d   = sync2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Synchroniser, counter and accepted level; reset means released.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
        end else begin
            sync1_q  <= raw;
            sync2_q  <= sync1_q;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
        end
    end

    assign stable = stable_q;
    assign rise   = rise_q;

endmodule

// File: rtl/piano_key_encoder.sv
// Debounces the note, flat and octave buttons and produces the registered sel/flat/
// octave code for the display and tone generator, plus a pulse on each new note.
module piano_key_encoder
    import piano_pkg::*;
#(
    parameter int N_KEYS       = 8,
    parameter int DEBOUNCE_CYC = 250000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_in,
    input  logic              flat_btn,
    input  logic              oct_btn,
    output logic [SEL_W-1:0]  sel,
    output logic              flat,
    output logic              octave,
    output logic              key_event
);

    localparam int N_BTN = N_KEYS + 2;

    logic [N_BTN-1:0]    btn_raw_s;
    logic [N_BTN-1:0]    btn_stable_s;
    logic [N_BTN-1:0]    btn_rise_s;
    logic [N_KEYS-1:0]   key_stable_s;
    logic                flat_stable_s;
    logic                oct_rise_s;
    logic                unused_s;

    logic [SEL_W-1:0]    sel_q;
    logic [SEL_W-1:0]    sel_d;
    logic                flat_q;
    logic                flat_d;
    logic                octave_q;
    logic                octave_d;
    logic                key_event_q;
    logic                key_event_d;

    // Bit layout: keys at the bottom, then flat, then octave on top.
    assign btn_raw_s = {oct_btn, flat_btn, key_in};

    for (genvar b = 0; b < N_BTN; b++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC)
        ) u_db (
            .clk   (clk),
            .rst   (rst),
            .raw   (btn_raw_s[b]),
            .stable(btn_stable_s[b]),
            .rise  (btn_rise_s[b])
        );
    end

    assign key_stable_s  = btn_stable_s[N_KEYS-1:0];
    assign flat_stable_s = btn_stable_s[N_KEYS];
    assign oct_rise_s    = btn_rise_s[N_KEYS+1];
    assign unused_s      = ^{btn_rise_s[N_KEYS:0], btn_stable_s[N_KEYS+1]};

    // Next output code; flat is only meaningful while a note is sounding.
    always_comb begin
        sel_d       = prio_encode(MAX_KEYS'(key_stable_s));
        flat_d      = 1'b0;
        key_event_d = 1'b0;
        octave_d    = octave_q;
        if (sel_d != SEL_NONE) begin
            flat_d      = flat_stable_s;
            key_event_d = (sel_d != sel_q);
        end else begin
            flat_d      = 1'b0;
            key_event_d = 1'b0;
        end
        if (oct_rise_s) begin
            octave_d = ~octave_q;
        end else begin
            octave_d = octave_q;
        end
    end

    // Output registers so nothing downstream ever sees a combinational glitch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_q       <= SEL_NONE;
            flat_q      <= 1'b0;
            octave_q    <= 1'b0;
            key_event_q <= 1'b0;
        end else begin
            sel_q       <= sel_d;
            flat_q      <= flat_d;
            octave_q    <= octave_d;
            key_event_q <= key_event_d;
        end
    end

    assign sel       = sel_q;
    assign flat      = flat_q;
    assign octave    = octave_q;
    assign key_event = key_event_q;

endmodule

// File: tb/tb_piano_key_encoder.sv
// Scoreboard bench: stimulus pushes timed expected output tuples, a negedge monitor
// pops one whenever the output tuple changes and checks both value and cycle.
module tb_piano_key_encoder;

    localparam int N_KEYS = 8;
    localparam int DEB    = 4;
    localparam int LAT    = DEB + 3;

    logic              clk;
    logic              rst;
    logic [N_KEYS-1:0] key_in;
    logic              flat_btn;
    logic              oct_btn;
    logic [3:0]        sel;
    logic              flat;
    logic              octave;
    logic              key_event;

    typedef struct {
        int         cyc;
        logic [6:0] val;
        string      name;
    } exp_t;

    exp_t       exp_q[$];
    int         cyc;
    int         chk_cnt;
    int         pass_cnt;
    bit         mon_en;
    logic [6:0] prev;

    piano_key_encoder #(
        .N_KEYS(N_KEYS),
        .DEBOUNCE_CYC(DEB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .key_in   (key_in),
        .flat_btn (flat_btn),
        .oct_btn  (oct_btn),
        .sel      (sel),
        .flat     (flat),
        .octave   (octave),
        .key_event(key_event)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic exp_at(input int dc, input logic [3:0] s, input logic f,
                          input logic o, input logic e, input string nm);
        exp_t x;
        x.cyc  = cyc + dc;
        x.val  = {s, f, o, e};
        x.name = nm;
        exp_q.push_back(x);
    endtask

    task automatic chk(input string nm, input logic [6:0] got, input logic [6:0] want);
        chk_cnt++;
        if (got === want) pass_cnt++;
        else $display("FAIL %s: got %h, want %h", nm, got, want);
    endtask

    // Monitor: every change of {sel,flat,octave,key_event} must match the queue head.
    initial begin
        logic [6:0] cur;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                cur = {sel, flat, octave, key_event};
                while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                    e = exp_q.pop_front();
                    chk_cnt++;
                    $display("FAIL %s: no change seen, wanted %h at cycle %0d (now %0d)",
                             e.name, e.val, e.cyc, cyc);
                end
                if (cur !== prev) begin
                    chk_cnt++;
                    if (exp_q.size() == 0) begin
                        $display("FAIL unexpected_change: got %h at cycle %0d, want %h (no change)",
                                 cur, cyc, prev);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.val === cur && e.cyc == cyc) pass_cnt++;
                        else $display("FAIL %s: got %h at cycle %0d, want %h at cycle %0d",
                                      e.name, cur, cyc, e.val, e.cyc);
                    end
                    prev = cur;
                end
            end
        end
    end

    initial begin
        chk_cnt  = 0;
        pass_cnt = 0;
        mon_en   = 1'b0;
        prev     = 7'h00;
        rst      = 1'b1;
        key_in   = 8'h01;
        flat_btn = 1'b0;
        oct_btn  = 1'b0;

        // 1: reset with key 0 held, then release
        #3 rst = 1'b0;
        tick(3);
        chk("reset_sel",    {3'd0, sel},       7'h00);
        chk("reset_flat",   {6'd0, flat},      7'h00);
        chk("reset_octave", {6'd0, octave},    7'h00);
        chk("reset_event",  {6'd0, key_event}, 7'h00);
        prev   = {sel, flat, octave, key_event};
        mon_en = 1'b1;
        rst    = 1'b1;
        exp_at(LAT,     4'd1, 1'b0, 1'b0, 1'b1, "rst_release_sel1_ev");
        exp_at(LAT + 1, 4'd1, 1'b0, 1'b0, 1'b0, "rst_release_ev_end");
        tick(12);
        key_in = 8'h00;
        exp_at(LAT, 4'd0, 1'b0, 1'b0, 1'b0, "release_k0_no_pulse");
        tick(12);

        // 2: bouncing key 2, then a short pulse on key 5
        for (int i = 0; i < 10; i++) begin
            key_in[2] = ~key_in[2];
            tick(1);
        end
        key_in[2] = 1'b1;
        exp_at(LAT,     4'd3, 1'b0, 1'b0, 1'b1, "bounce_settle_sel3");
        exp_at(LAT + 1, 4'd3, 1'b0, 1'b0, 1'b0, "bounce_ev_end");
        tick(12);
        key_in[2] = 1'b0;
        exp_at(LAT, 4'd0, 1'b0, 1'b0, 1'b0, "bounce_release");
        tick(12);
        key_in[5] = 1'b1;
        tick(3);
        key_in[5] = 1'b0;
        tick(12);

        // 3: priority hand-over
        key_in[4] = 1'b1;
        exp_at(LAT,     4'd5, 1'b0, 1'b0, 1'b1, "prio_k4_sel5");
        exp_at(LAT + 1, 4'd5, 1'b0, 1'b0, 1'b0, "prio_k4_ev_end");
        tick(12);
        key_in[1] = 1'b1;
        exp_at(LAT,     4'd2, 1'b0, 1'b0, 1'b1, "prio_k1_sel2");
        exp_at(LAT + 1, 4'd2, 1'b0, 1'b0, 1'b0, "prio_k1_ev_end");
        tick(12);
        key_in[1] = 1'b0;
        exp_at(LAT,     4'd5, 1'b0, 1'b0, 1'b1, "prio_back_sel5");
        exp_at(LAT + 1, 4'd5, 1'b0, 1'b0, 1'b0, "prio_back_ev_end");
        tick(12);
        key_in = 8'h00;
        exp_at(LAT, 4'd0, 1'b0, 1'b0, 1'b0, "prio_release_all");
        tick(12);

        // 4: flat gated by sel
        flat_btn = 1'b1;
        tick(12);
        key_in[6] = 1'b1;
        exp_at(LAT,     4'd7, 1'b1, 1'b0, 1'b1, "flat_k6_sel7_flat1");
        exp_at(LAT + 1, 4'd7, 1'b1, 1'b0, 1'b0, "flat_k6_ev_end");
        tick(12);
        flat_btn = 1'b0;
        exp_at(LAT, 4'd7, 1'b0, 1'b0, 1'b0, "flat_release");
        tick(12);
        key_in[6] = 1'b0;
        exp_at(LAT, 4'd0, 1'b0, 1'b0, 1'b0, "flat_k6_release");
        tick(12);

        // 5: octave toggle
        oct_btn = 1'b1;
        exp_at(LAT, 4'd0, 1'b0, 1'b1, 1'b0, "oct_first_toggle");
        tick(20);
        oct_btn = 1'b0;
        tick(12);
        oct_btn = 1'b1;
        exp_at(LAT, 4'd0, 1'b0, 1'b0, 1'b0, "oct_second_toggle");
        tick(12);
        oct_btn = 1'b0;
        tick(12);
        oct_btn   = 1'b1;
        key_in[0] = 1'b1;
        exp_at(LAT,     4'd1, 1'b0, 1'b1, 1'b1, "oct_and_key_together");
        exp_at(LAT + 1, 4'd1, 1'b0, 1'b1, 1'b0, "oct_and_key_ev_end");
        tick(12);
        oct_btn   = 1'b0;
        key_in[0] = 1'b0;
        exp_at(LAT, 4'd0, 1'b0, 1'b1, 1'b0, "oct_key_release");
        tick(12);

        // 6: reset while key 3 is held
        key_in[3] = 1'b1;
        exp_at(LAT,     4'd4, 1'b0, 1'b1, 1'b1, "mid_k3_sel4");
        exp_at(LAT + 1, 4'd4, 1'b0, 1'b1, 1'b0, "mid_k3_ev_end");
        tick(12);
        rst = 1'b0;
        exp_at(0, 4'd0, 1'b0, 1'b0, 1'b0, "mid_async_reset");
        tick(1);
        rst = 1'b1;
        exp_at(LAT,     4'd4, 1'b0, 1'b0, 1'b1, "mid_return_sel4");
        exp_at(LAT + 1, 4'd4, 1'b0, 1'b0, 1'b0, "mid_return_ev_end");
        tick(15);

        chk("scoreboard_drained", 7'(exp_q.size()), 7'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
